mem_arbiter: RTL and testbench

Two-client arbiter between the core's instruction-fetch port and data port and a single shared memory bus, so one single-port memory can serve both. It sits directly downstream of the core, consuming its imem and dmem valid/ready request interfaces. It grants one client at a time, captures the granted request into registers, and holds the shared bus stable until the memory responds. It then routes the response back to the granted client.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 34 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-client memory arbiter.
// The tie-break policy is selected by MEM_ARBITER_ROUND_ROBIN_EN (see mem_arb_select).
package mem_arbiter_pkg;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IMEM = 2'd1,
        S_DMEM = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        ARB_IMEM = 1'b0,
        ARB_DMEM = 1'b1
    } mem_arb_client_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant selection between imem and dmem requests.
// MEM_ARBITER_ROUND_ROBIN_EN defined: ties alternate against last_grant; undefined: dmem wins ties.
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic            imem_valid_i,
    input  logic            dmem_valid_i,
    input  mem_arb_client_t last_grant_i,
    output logic            grant_valid_o,
    output mem_arb_client_t grant_client_o
);

    assign grant_valid_o = imem_valid_i | dmem_valid_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        grant_client_o = ARB_IMEM;
        if (imem_valid_i && dmem_valid_i) begin
            grant_client_o = (last_grant_i == ARB_IMEM) ? ARB_DMEM : ARB_IMEM;
        end else if (dmem_valid_i) begin
            grant_client_o = ARB_DMEM;
        end
    end
`else
    // Fixed priority never consults the grant history.
    logic w_unused_last_grant;
    assign w_unused_last_grant = (last_grant_i == ARB_DMEM);

    always_comb begin
        grant_client_o = dmem_valid_i ? ARB_DMEM : ARB_IMEM;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core's imem and dmem ports onto one shared memory bus, holding the
// captured request until mem_ready_i. Tie policy: MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
    parameter int DATA_WIDTH = RISCV_WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    imem_valid_i,
    output logic                    imem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] imem_we_i,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,

    input  logic                    dmem_valid_i,
    output logic                    dmem_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,

    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    mem_arb_state_t               r_state;
    mem_arb_client_t              r_last_grant;
    logic                         r_mem_valid;
    logic [ADDR_WIDTH-1:0]        r_mem_addr;
    logic [DATA_WIDTH-1:0]        r_mem_wdata;
    logic [DATA_WIDTH/8-1:0]      r_mem_we;

    logic                         w_grant_valid;
    mem_arb_client_t              w_grant_client;

    mem_arb_select u_select (
        .imem_valid_i   (imem_valid_i),
        .dmem_valid_i   (dmem_valid_i),
        .last_grant_i   (r_last_grant),
        .grant_valid_o  (w_grant_valid),
        .grant_client_o (w_grant_client)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= ARB_IMEM;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant_client;
                        r_mem_valid  <= 1'b1;
                        if (w_grant_client == ARB_DMEM) begin
                            r_state     <= S_DMEM;
                            r_mem_addr  <= dmem_addr_i;
                            r_mem_wdata <= dmem_wdata_i;
                            r_mem_we    <= dmem_we_i;
                        end else begin
                            r_state     <= S_IMEM;
                            r_mem_addr  <= imem_addr_i;
                            r_mem_wdata <= imem_wdata_i;
                            r_mem_we    <= imem_we_i;
                        end
                    end
                end
                S_IMEM, S_DMEM: begin
                    // Captured request stays frozen until the memory answers.
                    if (mem_ready_i) begin
                        r_state     <= S_IDLE;
                        r_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // A client that withdrew its request gets no strobe; the response is dropped.
    assign imem_ready_o = !rst && (r_state == S_IMEM) && mem_ready_i && imem_valid_i;
    assign dmem_ready_o = !rst && (r_state == S_DMEM) && mem_ready_i && dmem_valid_i;

    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

    assign mem_valid_o = r_mem_valid;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_we_o    = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie-order expectations follow
// MEM_ARBITER_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid_i, dmem_valid_i, mem_ready_i;
    logic        imem_ready_o, dmem_ready_o, mem_valid_o;
    logic [31:0] imem_addr_i, imem_wdata_i, dmem_addr_i, dmem_wdata_i;
    logic [3:0]  imem_we_i, dmem_we_i, mem_we_o;
    logic [31:0] imem_rdata_o, dmem_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .imem_valid_i (imem_valid_i),
        .imem_ready_o (imem_ready_o),
        .imem_addr_i  (imem_addr_i),
        .imem_wdata_i (imem_wdata_i),
        .imem_we_i    (imem_we_i),
        .imem_rdata_o (imem_rdata_o),
        .dmem_valid_i (dmem_valid_i),
        .dmem_ready_o (dmem_ready_o),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_rdata_o (dmem_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_addr [3];

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h400; exp_addr[2] = 32'h500;
`else
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h500; exp_addr[2] = 32'h500;
`endif

        rst = 1'b1;
        imem_valid_i = 1'b0; imem_addr_i = '0; imem_wdata_i = '0; imem_we_i = '0;
        dmem_valid_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_we_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;

        // Reset, with requests and a stray memory strobe pending
        tick();
        imem_valid_i = 1'b1; dmem_valid_i = 1'b1; mem_ready_i = 1'b1;
        settle();
        chk("rst_imem_ready", imem_ready_o, 0);
        chk("rst_dmem_ready", dmem_ready_o, 0);
        tick();
        settle();
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_state", dut.r_state, S_IDLE);
        chk("rst_last_grant", dut.r_last_grant, ARB_IMEM);
        imem_valid_i = 1'b0; dmem_valid_i = 1'b0; mem_ready_i = 1'b0;
        rst = 1'b0;
        tick();
        $display("txn reset: mem_valid=%0d", mem_valid_o);

        // imem read, memory answers two cycles after mem_valid rises
        imem_valid_i = 1'b1; imem_addr_i = 32'h100;
        tick();
        settle();
        chk("t1_mem_valid", mem_valid_o, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_mem_we", mem_we_o, 0);
        chk("t1_wait_ready", imem_ready_o, 0);
        tick();
        settle();
        chk("t1_wait_ready2", imem_ready_o, 0);
        tick();
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        settle();
        chk("t1_imem_ready", imem_ready_o, 1);
        chk("t1_imem_rdata", imem_rdata_o, 32'h0000_0013);
        chk("t1_dmem_ready", dmem_ready_o, 0);
        tick();
        mem_ready_i = 1'b0; imem_valid_i = 1'b0;
        settle();
        chk("t1_valid_clear", mem_valid_o, 0);
        chk("t1_ready_pulse", imem_ready_o, 0);
        $display("txn imem_read: addr=%0h rdata=13", 32'h100);

        // Simultaneous requests: dmem first, imem after one idle bubble
        imem_valid_i = 1'b1; imem_addr_i = 32'h104;
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h2000; dmem_we_i = 4'hF; dmem_wdata_i = 32'hDEAD_BEEF;
        tick();
        settle();
        chk("t2_dmem_addr", mem_addr_o, 32'h2000);
        chk("t2_dmem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("t2_dmem_we", mem_we_o, 4'hF);
        mem_ready_i = 1'b1;
        settle();
        chk("t2_dmem_ready", dmem_ready_o, 1);
        chk("t2_imem_not_ready", imem_ready_o, 0);
        tick();
        mem_ready_i = 1'b0; dmem_valid_i = 1'b0; dmem_we_i = 4'h0;
        settle();
        chk("t2_bubble", mem_valid_o, 0);
        tick();
        settle();
        chk("t2_imem_valid", mem_valid_o, 1);
        chk("t2_imem_addr", mem_addr_o, 32'h104);
        chk("t2_imem_we", mem_we_o, 0);
        mem_ready_i = 1'b1;
        settle();
        chk("t2_imem_ready", imem_ready_o, 1);
        tick();
        mem_ready_i = 1'b0; imem_valid_i = 1'b0;
        $display("txn simultaneous: dmem 2000 then imem 104");

        // Three ties with both requests held continuously
        imem_valid_i = 1'b1; imem_addr_i = 32'h400;
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h500;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            chk("t3_tie_addr", mem_addr_o, exp_addr[k]);
            mem_ready_i = 1'b1;
            settle();
            chk("t3_tie_dready", dmem_ready_o, (exp_addr[k] == 32'h500) ? 1 : 0);
            chk("t3_tie_iready", imem_ready_o, (exp_addr[k] == 32'h400) ? 1 : 0);
            tick();
            mem_ready_i = 1'b0;
            settle();
            chk("t3_tie_bubble", mem_valid_o, 0);
            $display("txn tie %0d: addr=%0h", k, mem_addr_o);
        end
        imem_valid_i = 1'b0; dmem_valid_i = 1'b0;
        tick();

        // Request address changes while waiting; captured address must hold
        imem_valid_i = 1'b1; imem_addr_i = 32'h200;
        tick();
        imem_addr_i = 32'h300;
        settle();
        chk("t4_addr_cap", mem_addr_o, 32'h200);
        tick();
        settle();
        chk("t4_addr_hold", mem_addr_o, 32'h200);
        tick();
        mem_ready_i = 1'b1;
        settle();
        chk("t4_addr_at_ready", mem_addr_o, 32'h200);
        chk("t4_imem_ready", imem_ready_o, 1);
        tick();
        mem_ready_i = 1'b0; imem_valid_i = 1'b0;
        $display("txn addr_hold: addr=%0h", 32'h200);

        // Reset while dmem is granted
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h600; dmem_we_i = 4'h3;
        tick();
        settle();
        chk("t5_granted", mem_valid_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; dmem_valid_i = 1'b0; dmem_we_i = 4'h0; mem_ready_i = 1'b1;
        settle();
        chk("t5_mem_valid", mem_valid_o, 0);
        chk("t5_state", dut.r_state, S_IDLE);
        chk("t5_no_dready", dmem_ready_o, 0);
        chk("t5_no_iready", imem_ready_o, 0);
        tick();
        mem_ready_i = 1'b0;
        settle();
        chk("t5_still_idle", dut.r_state, S_IDLE);
        chk("t5_still_invalid", mem_valid_o, 0);
        $display("txn reset_abort: dmem 600 dropped");

        // dmem withdraws its request mid-transaction
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h700;
        tick();
        dmem_valid_i = 1'b0;
        settle();
        chk("t6_granted", mem_valid_o, 1);
        tick();
        settle();
        chk("t6_held", mem_addr_o, 32'h700);
        mem_ready_i = 1'b1;
        settle();
        chk("t6_no_dready", dmem_ready_o, 0);
        tick();
        mem_ready_i = 1'b0;
        settle();
        chk("t6_idle", dut.r_state, S_IDLE);
        chk("t6_valid_clear", mem_valid_o, 0);
        $display("txn dropped_valid: dmem 700 discarded");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
